vertex_rotate_z: RTL and testbench

//  Rotates one 3D vertex about the Z axis by an integer angle in degrees. It sits directly

---
 rtl/vertex_rotate_z.sv | 111 +++++++++++
 tb/tb_vertex_rotate_z.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/vertex_rotate_z.sv
// vertex_rotate_z: rotate one vertex about Z by a ROM-supplied cos/sin using one shared multiplier
// Ports: clk/rst_n clock and async active-low reset; in_valid/in_ready/in_angle/in_x/in_y/in_z request;
//   trig_angle out to the cos/sin ROMs, cos_in/sin_in back; out_valid/out_ready/out_x/out_y/out_z/out_sat result.
module vertex_rotate_z #(
  parameter int COORD_W   = 16,
  parameter int TRIG_W    = 16,
  parameter int TRIG_FRAC = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [15:0]               in_angle,
  input  logic signed [COORD_W-1:0] in_x,
  input  logic signed [COORD_W-1:0] in_y,
  input  logic signed [COORD_W-1:0] in_z,
  output logic [15:0]               trig_angle,
  input  logic signed [TRIG_W-1:0]  cos_in,
  input  logic signed [TRIG_W-1:0]  sin_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [COORD_W-1:0] out_x,
  output logic signed [COORD_W-1:0] out_y,
  output logic signed [COORD_W-1:0] out_z,
  output logic                      out_sat
);
  localparam int AW = 2*COORD_W+2;
  localparam int PW = COORD_W+TRIG_W;
  typedef enum logic [2:0] {IDLE, LOOKUP, MUL0, MUL1, MUL2, MUL3, OUT} state_t;
  state_t                    r_state;
  logic signed [COORD_W-1:0] r_x, r_y, r_z, r_xr;
  logic signed [TRIG_W-1:0]  r_c, r_s;
  logic signed [AW-1:0]      r_acc;
  logic                      r_xsat;
  logic signed [COORD_W-1:0] w_a, w_res;
  logic signed [TRIG_W-1:0]  w_b;
  logic signed [PW-1:0]      w_prod;
  logic signed [AW-1:0]      w_sum, w_shift;
  logic                      w_ovf;
  assign in_ready = (r_state == IDLE);
  // operand schedule: MUL0 x*c, MUL1 y*s, MUL2 x*s, MUL3 y*c
  assign w_a     = (r_state == MUL0 || r_state == MUL2) ? r_x : r_y;
  assign w_b     = (r_state == MUL0 || r_state == MUL3) ? r_c : r_s;
  assign w_prod  = w_a * w_b;
  assign w_sum   = (r_state == MUL1) ? r_acc - AW'(w_prod) : r_acc + AW'(w_prod);
  assign w_shift = w_sum >>> TRIG_FRAC;
  // fits in COORD_W only if every bit above the result sign matches it
  assign w_ovf   = |w_shift[AW-1:COORD_W-1] && !(&w_shift[AW-1:COORD_W-1]);
  assign w_res   = !w_ovf ? w_shift[COORD_W-1:0] :
                   w_shift[AW-1] ? {1'b1, {(COORD_W-1){1'b0}}} : {1'b0, {(COORD_W-1){1'b1}}};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_xr       <= '0;
      r_c        <= '0;
      r_s        <= '0;
      r_acc      <= '0;
      r_xsat     <= 1'b0;
      trig_angle <= '0;
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_z      <= '0;
      out_sat    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_x        <= in_x;
          r_y        <= in_y;
          r_z        <= in_z;
          trig_angle <= in_angle;
          r_state    <= LOOKUP;
        end
        LOOKUP: begin
          r_c     <= cos_in;
          r_s     <= sin_in;
          r_state <= MUL0;
        end
        MUL0: begin
          r_acc   <= AW'(w_prod);
          r_state <= MUL1;
        end
        MUL1: begin
          r_xr    <= w_res;
          r_xsat  <= w_ovf;
          r_state <= MUL2;
        end
        MUL2: begin
          r_acc   <= AW'(w_prod);
          r_state <= MUL3;
        end
        MUL3: begin
          out_x     <= r_xr;
          out_y     <= w_res;
          out_z     <= r_z;
          out_sat   <= r_xsat | w_ovf;
          out_valid <= 1'b1;
          r_state   <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vertex_rotate_z.sv
// tb_vertex_rotate_z: directed vectors with hand-computed rotations against vertex_rotate_z
module tb_vertex_rotate_z;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [15:0]        in_angle = '0;
  logic signed [15:0] in_x = '0, in_y = '0, in_z = '0;
  logic [15:0]        trig_angle;
  logic signed [15:0] cos_in, sin_in;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] out_x, out_y, out_z;
  logic               out_sat;
  int                 n_chk = 0;
  int                 n_pass = 0;
  vertex_rotate_z dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .trig_angle(trig_angle), .cos_in(cos_in), .sin_in(sin_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_sat(out_sat)
  );
  always #5 clk = ~clk;
  // tiny cos/sin ROM; angle 500 is a fake entry giving cos=sin=255 for the saturation case
  always_comb begin
    cos_in = '0;
    sin_in = '0;
    case (trig_angle)
      16'd0:   begin cos_in = 16'sd255;  sin_in = 16'sd0;   end
      16'd45:  begin cos_in = 16'sd181;  sin_in = 16'sd181; end
      16'd90:  begin cos_in = 16'sd0;    sin_in = 16'sd255; end
      16'd180: begin cos_in = -16'sd255; sin_in = 16'sd0;   end
      16'd500: begin cos_in = 16'sd255;  sin_in = 16'sd255; end
      default: ;
    endcase
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int a, input int x, input int y, input int z);
    in_angle = 16'(a);
    in_x     = 16'(x);
    in_y     = 16'(y);
    in_z     = 16'(z);
    in_valid = 1'b1;
  endtask
  task automatic send(input int a, input int x, input int y, input int z);
    int n;
    n = 0;
    drive(a, x, y, z);
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask
  task automatic chk_out(input string tag, input int ex, input int ey, input int ez, input int es);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_x"}, int'(out_x), ex);
    chk({tag, "_y"}, int'(out_y), ey);
    chk({tag, "_z"}, int'(out_z), ez);
    chk({tag, "_sat"}, int'(out_sat), es);
  endtask
  // full transaction with out_ready high: accept at edge N, valid after N+5, handshake at N+6
  task automatic run(input string tag, input int a, input int x, input int y, input int z,
                     input int ex, input int ey, input int ez, input int es);
    send(a, x, y, z);
    chk({tag, "_busy"}, int'(in_ready), 0);
    chk({tag, "_angle"}, int'(trig_angle), a);
    repeat (4) tick();
    chk({tag, "_early"}, int'(out_valid), 0);
    tick();
    chk_out(tag, ex, ey, ez, es);
    tick();
    chk({tag, "_done"}, int'(out_valid), 0);
    chk({tag, "_idle"}, int'(in_ready), 1);
    chk({tag, "_hold"}, int'(trig_angle), a);
  endtask
  initial begin
    int seen;
    #3;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_x", int'(out_x), 0);
    chk("rst_angle", int'(trig_angle), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run("t1", 0, 100, 50, 7, 99, 49, 7, 0);
    run("t2", 90, 100, 50, 7, -50, 99, 7, 0);
    run("t3", 500, 32767, -32768, 1, 32767, -1, 1, 1);
    run("t180", 180, 100, -30, -5, -100, 29, -5, 0);
    // back-pressure
    out_ready = 1'b0;
    send(90, 100, 50, -2);
    repeat (5) tick();
    for (int i = 0; i < 10; i++) begin
      chk_out("t4", -50, 99, -2, 0);
      chk("t4_busy", int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t4_release_valid", int'(out_valid), 0);
    chk("t4_release_idle", int'(in_ready), 1);
    // request arriving while busy (raised in MUL1) waits for IDLE
    send(45, 200, 100, 3);
    repeat (2) tick();
    drive(0, 1000, -1000, 9);
    repeat (3) tick();
    chk_out("t5a", 70, 212, 3, 0);
    tick();
    chk("t5_idle", int'(in_ready), 1);
    chk("t5_valid_low", int'(out_valid), 0);
    tick();
    in_valid = 1'b0;
    chk("t5_accepted", int'(in_ready), 0);
    chk("t5_angle", int'(trig_angle), 0);
    repeat (4) tick();
    chk("t5b_early", int'(out_valid), 0);
    tick();
    chk_out("t5b", 996, -997, 9, 0);
    tick();
    // reset in MUL2
    send(180, 100, -30, -5);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", int'(out_valid), 0);
    chk("t6_ready", int'(in_ready), 1);
    chk("t6_x", int'(out_x), 0);
    chk("t6_y", int'(out_y), 0);
    chk("t6_z", int'(out_z), 0);
    chk("t6_sat", int'(out_sat), 0);
    chk("t6_angle", int'(trig_angle), 0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen = 1;
    end
    chk("t6_no_out", seen, 0);
    run("t6_fresh", 180, 100, -30, -5, -100, 29, -5, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
